modaddsub_pipe: RTL and testbench

- Parametrised, pipelined modular add/subtract/negate unit for the polynomial arithmetic datapath.
- Processes LANES independent coefficient pairs per transfer. Each transfer carries one shared opcode.
- Valid/ready handshake on both sides, full throughput of one transfer per cycle, fixed 2-cycle latency when unstalled.
- Sits between the coefficient memories and the butterfly/NTT units and replaces the single-lane combinational subtractor.

---
 rtl/modarith_pkg.sv | 18 +
 rtl/modaddsub_lane.sv | 60 ++++++
 rtl/modaddsub_pipe.sv | 135 +++++++++++++
 tb/tb_modaddsub_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/modarith_pkg.sv
// Shared definitions for the modular coefficient arithmetic datapath:
// default field sizes, the 2-bit opcode encoding and the coefficient type.
package modarith_pkg;

  localparam int unsigned W_DEF     = 12;
  localparam int unsigned Q_DEF     = 3329;
  localparam int unsigned LANES_DEF = 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NEG  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef logic [W_DEF-1:0] coef_t;

endpackage

// File: rtl/modaddsub_lane.sv
// One coefficient lane: computes the raw and corrected sums on the input side
// and picks the reduced result from the registered values on the output side.
module modaddsub_lane
  import modarith_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned Q = Q_DEF
) (
  input  op_e          op_p0,
  input  logic [W-1:0] a_p0,
  input  logic [W-1:0] b_p0,
  output logic [W:0]   raw_p0,
  output logic [W-1:0] corr_p0,
  input  op_e          op_p1,
  input  logic [W-1:0] a_p1,
  input  logic [W:0]   raw_p1,
  input  logic [W-1:0] corr_p1,
  output logic [W-1:0] c_p1
);

  localparam logic [W:0]   QX = (W+1)'(Q);
  localparam logic [W-1:0] QW = W'(Q);

  function automatic logic [W:0] raw_calc(input op_e op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      default: return '0;
    endcase
  endfunction

  // The correction is only ever needed modulo 2^W, so the top bit is dropped.
  function automatic logic [W-1:0] corr_calc(input op_e op, input logic [W:0] raw);
    case (op)
      OP_ADD:  return W'(raw - QX);
      OP_SUB:  return W'(raw + QX);
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] mod_select(input op_e op, input logic [W-1:0] a,
                                              input logic [W:0] raw,
                                              input logic [W-1:0] corr);
    case (op)
      OP_ADD:  return (raw >= QX) ? corr : raw[W-1:0];
      OP_SUB:  return raw[W] ? corr : raw[W-1:0];
      OP_NEG:  return (a == '0) ? '0 : W'(QW - a);
      default: return a;
    endcase
  endfunction

  // ---- stage p0 -> p1: raw/corrected values ----
  assign raw_p0  = raw_calc(op_p0, a_p0, b_p0);
  assign corr_p0 = corr_calc(op_p0, raw_p0);

  // ---- stage p1 -> p2: reduction select ----
  assign c_p1 = mod_select(op_p1, a_p1, raw_p1, corr_p1);

endmodule

// File: rtl/modaddsub_pipe.sv
// Two-stage LANES-wide modular add/sub/negate/pass unit with valid/ready on
// both sides and a sticky range-error flag for non-canonical operands.
module modaddsub_pipe
  import modarith_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned Q     = Q_DEF,
  parameter int unsigned LANES = LANES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_c,
  output logic               err_range,
  input  logic               clr_err
);

  localparam int unsigned LW  = LANES * W;
  localparam int unsigned LRW = LANES * (W + 1);
  localparam logic [W-1:0] QW = W'(Q);

  op_e             op_p0;
  logic [LRW-1:0]  raw_p0;
  logic [LW-1:0]   corr_p0;
  logic [LW-1:0]   c_p1;
  logic [LANES-1:0] bad_lane;

  logic            vld_p1_q, vld_p1_d;
  logic            vld_p2_q, vld_p2_d;
  logic            err_q, err_d;
  logic [LW-1:0]   out_c_q, out_c_d;
  op_e             op_p1_q, op_p1_d;
  logic [LW-1:0]   a_p1_q, a_p1_d;
  logic [LRW-1:0]  raw_p1_q, raw_p1_d;
  logic [LW-1:0]   corr_p1_q, corr_p1_d;

  logic s2_adv, s1_move, in_xfer;

  assign op_p0 = op_e'(in_op);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    modaddsub_lane #(
      .W (W),
      .Q (Q)
    ) u_lane (
      .op_p0   (op_p0),
      .a_p0    (in_a[i*W +: W]),
      .b_p0    (in_b[i*W +: W]),
      .raw_p0  (raw_p0[i*(W+1) +: (W+1)]),
      .corr_p0 (corr_p0[i*W +: W]),
      .op_p1   (op_p1_q),
      .a_p1    (a_p1_q[i*W +: W]),
      .raw_p1  (raw_p1_q[i*(W+1) +: (W+1)]),
      .corr_p1 (corr_p1_q[i*W +: W]),
      .c_p1    (c_p1[i*W +: W])
    );

    // B only matters to add/sub, so it is range-checked only for those ops.
    assign bad_lane[i] = (in_a[i*W +: W] >= QW) ||
                         (((op_p0 == OP_ADD) || (op_p0 == OP_SUB)) && (in_b[i*W +: W] >= QW));
  end

  assign s2_adv   = !vld_p2_q || out_ready;
  assign s1_move  = vld_p1_q && s2_adv;
  assign in_ready = !vld_p1_q || s1_move;
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    vld_p1_d  = vld_p1_q;
    vld_p2_d  = vld_p2_q;
    err_d     = err_q;
    out_c_d   = out_c_q;
    op_p1_d   = op_p1_q;
    a_p1_d    = a_p1_q;
    raw_p1_d  = raw_p1_q;
    corr_p1_d = corr_p1_q;

    // ---- stage p0 -> p1: accept ----
    if (in_xfer) begin
      vld_p1_d  = 1'b1;
      op_p1_d   = op_p0;
      a_p1_d    = in_a;
      raw_p1_d  = raw_p0;
      corr_p1_d = corr_p0;
    end else if (s1_move) begin
      vld_p1_d = 1'b0;
    end

    // ---- stage p1 -> p2: output register; holds while stalled ----
    if (s2_adv) begin
      vld_p2_d = vld_p1_q;
    end
    if (s1_move) begin
      out_c_d = c_p1;
    end

    if (in_xfer && (|bad_lane)) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      err_q    <= 1'b0;
      out_c_q  <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      err_q    <= err_d;
      out_c_q  <= out_c_d;
    end
  end

  always_ff @(posedge clk) begin
    op_p1_q   <= op_p1_d;
    a_p1_q    <= a_p1_d;
    raw_p1_q  <= raw_p1_d;
    corr_p1_q <= corr_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_c     = out_c_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_modaddsub_pipe.sv
// Directed and randomised bench for modaddsub_pipe against a modular-arithmetic
// reference model and an in-order expected-result queue.
module tb_modaddsub_pipe;

  localparam int W     = 12;
  localparam int Q     = 3329;
  localparam int LANES = 4;
  localparam int LW    = LANES * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [1:0]    in_op;
  logic [LW-1:0] in_a, in_b;
  logic          out_valid, out_ready;
  logic [LW-1:0] out_c;
  logic          err_range, clr_err;

  int tests = 0;
  int fails = 0;
  logic [LW-1:0] exp_q[$];

  always #5 clk = ~clk;

  modaddsub_pipe #(.W(W), .Q(Q), .LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .err_range (err_range),
    .clr_err   (clr_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [LW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    logic [LW-1:0] r;
    r = '0;
    r[0*W +: W] = W'(l0);
    r[1*W +: W] = W'(l1);
    r[2*W +: W] = W'(l2);
    r[3*W +: W] = W'(l3);
    return r;
  endfunction

  function automatic logic [LW-1:0] rand_canon();
    return pack($urandom_range(0, Q-1), $urandom_range(0, Q-1),
                $urandom_range(0, Q-1), $urandom_range(0, Q-1));
  endfunction

  // Mathematical result per lane: (A+B) mod Q, (A-B) mod Q, (-A) mod Q, A.
  function automatic logic [LW-1:0] model(input logic [1:0] op, input logic [LW-1:0] a,
                                          input logic [LW-1:0] b);
    logic [LW-1:0] r;
    int x, y, z;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      x = int'(a[i*W +: W]);
      y = int'(b[i*W +: W]);
      case (op)
        2'd0:    z = (x + y) % Q;
        2'd1:    z = (x - y + Q) % Q;
        2'd2:    z = (Q - x) % Q;
        default: z = x;
      endcase
      r[i*W +: W] = W'(z);
    end
    return r;
  endfunction

  // One clock: drive, sample handshake at the falling edge, check after the rising edge.
  task automatic step(input bit iv, input logic [1:0] op, input logic [LW-1:0] a,
                      input logic [LW-1:0] b, input bit ordy, input bit clr, output bit acc);
    bit dlv, stall;
    logic [LW-1:0] c_seen, e;
    in_valid  = iv;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    clr_err   = clr;
    @(negedge clk);
    chk("in_ready", in_ready, !((exp_q.size() == 2) && !ordy));
    acc    = in_valid && in_ready;
    dlv    = out_valid && out_ready;
    stall  = out_valid && !out_ready;
    c_seen = out_c;
    @(posedge clk);
    #1;
    if (dlv) begin
      chk("result_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("result_order", c_seen, e);
      end
    end
    if (stall) begin
      chk("stall_valid_hold", out_valid, 1'b1);
      chk("stall_data_hold", out_c, c_seen);
    end
    if (acc) exp_q.push_back(model(op, a, b));
  endtask

  task automatic idle(input bit ordy, input bit clr);
    bit acc;
    step(1'b0, 2'd0, '0, '0, ordy, clr, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1, 1'b0);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Single transfer into an empty pipe: check latency and the literal result.
  task automatic directed(input string tag, input logic [1:0] op, input logic [LW-1:0] a,
                          input logic [LW-1:0] b, input logic [LW-1:0] expv);
    bit acc;
    step(1'b1, op, a, b, 1'b1, 1'b0, acc);
    chk({tag, "_accept"}, acc, 1'b1);
    chk({tag, "_lat_not_yet"}, out_valid, 1'b0);
    idle(1'b0, 1'b0);
    chk({tag, "_lat_valid"}, out_valid, 1'b1);
    chk({tag, "_value"}, out_c, expv);
    idle(1'b1, 1'b0);
    chk({tag, "_consumed"}, out_valid, 1'b0);
  endtask

  initial begin
    bit acc;
    int n, cyc;
    logic [LW-1:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0;
    out_ready = 1'b0; clr_err = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_c", out_c, '0);
    chk("rst_err", err_range, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    directed("sub", 2'd1, pack(5, 0, 3328, 100), pack(10, 0, 3328, 1), pack(3324, 0, 0, 99));
    directed("add", 2'd0, pack(3000, 3328, 1664, 0), pack(500, 3328, 1665, 0),
             pack(171, 3327, 0, 0));
    directed("neg", 2'd2, pack(0, 1, 3328, 1000), pack(7, 3000, 4095, 12),
             pack(0, 3328, 1, 2329));
    directed("pass", 2'd3, pack(17, 3328, 0, 2048), pack(1, 2, 3, 4), pack(17, 3328, 0, 2048));
    directed("sub_0_minus_qm1", 2'd1, pack(0, 0, 7, 0), pack(3328, 1, 7, 0),
             pack(1, 3328, 0, 0));
    chk("err_after_canonical", err_range, 1'b0);

    // 8 back-to-back transfers with out_ready pattern 1,0,0,1
    n = 0;
    cyc = 0;
    while (n < 8 && cyc < 100) begin
      ra = rand_canon();
      rb = rand_canon();
      step(1'b1, 2'($urandom_range(0, 3)), ra, rb, (cyc % 4 == 0) || (cyc % 4 == 3), 1'b0, acc);
      if (acc) n++;
      cyc++;
    end
    chk("burst_all_accepted", 64'(n), 64'd8);
    drain();

    // Sticky range error
    step(1'b1, 2'd0, pack(1, 2, 3329, 4), pack(5, 6, 5, 8), 1'b1, 1'b0, acc);
    chk("err_set_on_accept", err_range, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("err_sticky", err_range, 1'b1);
    idle(1'b1, 1'b1);
    chk("err_cleared", err_range, 1'b0);
    step(1'b1, 2'd2, pack(1, 2, 3, 4), pack(4000, 4095, 3329, 3500), 1'b1, 1'b0, acc);
    chk("err_b_ignored_neg", err_range, 1'b0);
    step(1'b1, 2'd1, pack(1, 2, 3, 4), pack(0, 0, 0, 3329), 1'b1, 1'b1, acc);
    chk("err_set_beats_clr", err_range, 1'b1);
    idle(1'b1, 1'b1);
    chk("err_cleared_again", err_range, 1'b0);
    drain();

    // Asynchronous reset with two transfers in flight
    step(1'b1, 2'd0, rand_canon(), rand_canon(), 1'b0, 1'b0, acc);
    step(1'b1, 2'd1, rand_canon(), rand_canon(), 1'b0, 1'b0, acc);
    idle(1'b0, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_out_c", out_c, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rerelease_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, 1'b0);
      chk("no_stale_result", out_valid, 1'b0);
    end

    // Randomised transfers with random backpressure
    n = 0;
    cyc = 0;
    while (n < 10000 && cyc < 40000) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_canon(), rand_canon(),
           $urandom_range(0, 3) != 0, 1'b0, acc);
      if (acc) n++;
      cyc++;
    end
    chk("random_all_accepted", 64'(n), 64'd10000);
    drain();
    chk("random_no_err", err_range, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
